// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the falling-cubes game-flow controller.
package secuenciador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } estado_e;

  localparam int ALTURA_W        = 3;
  localparam int NIVEL_W         = 2;
  localparam int VIDAS_W         = 2;
  localparam int PRESC_W         = 25;
  localparam int VIDAS_INICIALES = 3;
  localparam int NIVEL_MAX       = 3;

endpackage

// File: rtl/divisor_tick.sv
// Fall-rate prescaler: counts 0..periodo-1 while enabled and pulses tick on the last count.
module divisor_tick
  import secuenciador_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] periodo,
  output logic               tick
);

  logic [PRESC_W-1:0] cuenta_q, cuenta_d;

  // ">=" rather than "==" so a shorter period after a level-up wraps at once.
  always_comb begin
    tick     = enable && (cuenta_q >= (periodo - PRESC_W'(1)));
    cuenta_d = cuenta_q;
    if (clear)       cuenta_d = '0;
    else if (tick)   cuenta_d = '0;
    else if (enable) cuenta_d = cuenta_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cuenta_q <= '0;
    else        cuenta_q <= cuenta_d;
  end

endmodule

// File: rtl/secuenciador_cubos.sv
// Game-flow controller: FSM, fall height, lives, level and hit counting for falling cubes.
// Inputs are sampled on the rising edge; all game outputs come straight from registers.
module secuenciador_cubos
  import secuenciador_pkg::*;
#(
  parameter int BASE_PERIOD    = 25_000_000,
  parameter int STEP_PERIOD    = 5_000_000,
  parameter int FALL_STEPS     = 8,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pausa,
  input  logic                acierto,
  input  logic                fallo,
  output logic                rotar,
  output logic                paso_caida,
  output logic [ALTURA_W-1:0] altura,
  output logic [NIVEL_W-1:0]  nivel,
  output logic [VIDAS_W-1:0]  vidas,
  output logic                juego_activo,
  output logic                fin_juego,
  output estado_e             estado_dbg
);

  localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [ALTURA_W-1:0] ALTURA_FONDO = ALTURA_W'(FALL_STEPS - 1);

  estado_e             estado_q, estado_d;
  logic [ALTURA_W-1:0] altura_q, altura_d;
  logic [NIVEL_W-1:0]  nivel_q, nivel_d;
  logic [VIDAS_W-1:0]  vidas_q, vidas_d;
  logic [HW-1:0]       aciertos_q, aciertos_d;
  logic                rotar_q, rotar_d;
  logic                paso_q, paso_d;
  logic                activo_q, fin_q;

  logic               presc_en, presc_clr, tick;
  logic [PRESC_W-1:0] periodo;

  // A RUN cycle with pausa high is already frozen, so the count stops where it is.
  assign presc_en = (estado_q == RUN) && !pausa;
  assign periodo  = PRESC_W'(BASE_PERIOD - int'(nivel_q) * STEP_PERIOD);

  divisor_tick u_divisor (
    .clk    (clk),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .periodo(periodo),
    .tick   (tick)
  );

  always_comb begin
    estado_d   = estado_q;
    altura_d   = altura_q;
    nivel_d    = nivel_q;
    vidas_d    = vidas_q;
    aciertos_d = aciertos_q;
    rotar_d    = 1'b0;
    paso_d     = 1'b0;
    presc_clr  = 1'b0;
    case (estado_q)
      IDLE, OVER: begin
        if (start) begin
          estado_d   = RUN;
          vidas_d    = VIDAS_W'(VIDAS_INICIALES);
          nivel_d    = '0;
          altura_d   = '0;
          aciertos_d = '0;
          presc_clr  = 1'b1;
        end
      end
      RUN: begin
        if (pausa) begin
          estado_d = PAUSE;
        end else if (acierto) begin
          altura_d  = '0;
          presc_clr = 1'b1;
          rotar_d   = 1'b1;
          if (aciertos_q == HW'(HITS_PER_LEVEL - 1)) begin
            aciertos_d = '0;
            if (nivel_q != NIVEL_W'(NIVEL_MAX)) nivel_d = nivel_q + NIVEL_W'(1);
          end else begin
            aciertos_d = aciertos_q + HW'(1);
          end
        end else if (fallo || (tick && altura_q == ALTURA_FONDO)) begin
          // Explicit miss outranks the bottom miss; either way one retirement only.
          altura_d  = '0;
          presc_clr = 1'b1;
          rotar_d   = 1'b1;
          if (vidas_q == VIDAS_W'(1)) begin
            vidas_d  = '0;
            estado_d = OVER;
          end else begin
            vidas_d = vidas_q - VIDAS_W'(1);
          end
        end else if (tick) begin
          altura_d = altura_q + ALTURA_W'(1);
          paso_d   = 1'b1;
        end
      end
      PAUSE: begin
        if (!pausa) estado_d = RUN;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= IDLE;
      altura_q   <= '0;
      nivel_q    <= '0;
      vidas_q    <= VIDAS_W'(VIDAS_INICIALES);
      aciertos_q <= '0;
      rotar_q    <= 1'b0;
      paso_q     <= 1'b0;
      activo_q   <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      altura_q   <= altura_d;
      nivel_q    <= nivel_d;
      vidas_q    <= vidas_d;
      aciertos_q <= aciertos_d;
      rotar_q    <= rotar_d;
      paso_q     <= paso_d;
      activo_q   <= (estado_d == RUN) || (estado_d == PAUSE);
      fin_q      <= (estado_d == OVER);
    end
  end

  assign rotar        = rotar_q;
  assign paso_caida   = paso_q;
  assign altura       = altura_q;
  assign nivel        = nivel_q;
  assign vidas        = vidas_q;
  assign juego_activo = activo_q;
  assign fin_juego    = fin_q;
  assign estado_dbg   = estado_q;

endmodule

// File: tb/tb_secuenciador_cubos.sv
// Directed bench for secuenciador_cubos with BASE_PERIOD=20, STEP_PERIOD=5, 8 steps, 4 hits/level.
module tb_secuenciador_cubos;
  import secuenciador_pkg::*;

  logic clk, reset, start, pausa, acierto, fallo;
  logic rotar, paso_caida, juego_activo, fin_juego;
  logic [2:0] altura;
  logic [1:0] nivel, vidas;
  estado_e estado_dbg;

  int nvec = 0;
  int nerr = 0;

  secuenciador_cubos #(
    .BASE_PERIOD(20), .STEP_PERIOD(5), .FALL_STEPS(8), .HITS_PER_LEVEL(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pausa(pausa),
    .acierto(acierto), .fallo(fallo), .rotar(rotar), .paso_caida(paso_caida),
    .altura(altura), .nivel(nivel), .vidas(vidas),
    .juego_activo(juego_activo), .fin_juego(fin_juego), .estado_dbg(estado_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  // Driver tasks: step one clock and settle just after the active edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from now until paso_caida is seen high (bounded)
  task automatic wait_paso(input int max, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (paso_caida !== 1'b1 && n < max);
  endtask

  task automatic wait_rotar(input int max, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (rotar !== 1'b1 && n < max);
  endtask

  task automatic hit();
    cyc();
    acierto = 1'b1;
    cyc();
    acierto = 1'b0;
    chk("hit_rotar", rotar, 1);
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_activo", juego_activo, 1);
    chk("start_vidas", vidas, 3);
    chk("start_nivel", nivel, 0);
    chk("start_altura", altura, 0);
  endtask

  initial begin
    int n;
    int pulsos;
    reset = 1'b0; start = 1'b0; pausa = 1'b0; acierto = 1'b0; fallo = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_vidas", vidas, 3);
    chk("rst_nivel", nivel, 0);
    chk("rst_altura", altura, 0);
    chk("rst_activo", juego_activo, 0);
    chk("rst_fin", fin_juego, 0);
    chk("rst_pulsos", {rotar, paso_caida}, 0);
    chk("rst_estado", estado_dbg, IDLE);
    reset = 1'b1;
    cyc();

    // 1: fall steps every 20 cycles, altura 0 -> 7
    start_game();
    for (int i = 1; i <= 7; i++) begin
      wait_paso(60, n);
      chk("t1_gap", n, 20);
      chk("t1_altura", altura, i);
    end

    // 2: bottom misses drain lives to game over
    wait_rotar(60, n);
    chk("t2_gap", n, 20);
    chk("t2_altura", altura, 0);
    chk("t2_vidas", vidas, 2);
    chk("t2_no_paso", paso_caida, 0);
    cyc();
    chk("t2_rotar_1cyc", rotar, 0);
    wait_rotar(250, n);
    chk("t2_gap2", n, 159);
    chk("t2_vidas2", vidas, 1);
    wait_rotar(250, n);
    chk("t2_gap3", n, 160);
    chk("t2_vidas0", vidas, 0);
    chk("t2_fin", fin_juego, 1);
    chk("t2_activo", juego_activo, 0);
    chk("t2_altura0", altura, 0);
    // acierto/pausa ignored in OVER
    acierto = 1'b1; pausa = 1'b1;
    cyc();
    acierto = 1'b0; pausa = 1'b0;
    cyc();
    chk("t2_over_rotar", rotar, 0);
    chk("t2_over_estado", estado_dbg, OVER);
    chk("t2_over_vidas", vidas, 0);

    // 5: pause at prescaler count 10 for 50 cycles
    start_game();
    repeat (10) cyc();
    pausa = 1'b1;
    pulsos = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) acierto = 1'b1;
      if (i == 21) acierto = 1'b0;
      cyc();
      if (rotar === 1'b1 || paso_caida === 1'b1) pulsos++;
    end
    chk("t5_no_pulsos", pulsos, 0);
    chk("t5_estado", estado_dbg, PAUSE);
    chk("t5_activo", juego_activo, 1);
    chk("t5_altura", altura, 0);
    pausa = 1'b0;
    cyc();
    chk("t5_resume", estado_dbg, RUN);
    wait_paso(60, n);
    chk("t5_gap", n, 10);
    chk("t5_altura1", altura, 1);

    // 3: levels and tick spacing
    repeat (4) hit();
    chk("t3_nivel1", nivel, 1);
    chk("t3_altura", altura, 0);
    wait_paso(60, n);
    chk("t3_gap15", n, 15);
    wait_paso(60, n);
    chk("t3_gap15b", n, 15);
    repeat (4) hit();
    chk("t3_nivel2", nivel, 2);
    repeat (4) hit();
    chk("t3_nivel3", nivel, 3);
    repeat (4) hit();
    chk("t3_nivel_sat", nivel, 3);
    chk("t3_vidas", vidas, 3);
    wait_paso(60, n);
    chk("t3_gap5", n, 5);

    // 4: acierto + fallo on the bottom tick -> a single hit
    for (int i = 0; i < 6 && altura != 3'd7; i++) wait_paso(20, n);
    chk("t4_altura7", altura, 7);
    repeat (4) cyc();
    acierto = 1'b1; fallo = 1'b1;
    cyc();
    acierto = 1'b0; fallo = 1'b0;
    chk("t4_rotar", rotar, 1);
    chk("t4_vidas", vidas, 3);
    chk("t4_altura", altura, 0);
    chk("t4_no_paso", paso_caida, 0);
    cyc();
    chk("t4_rotar_1cyc", rotar, 0);
    fallo = 1'b1;
    cyc();
    fallo = 1'b0;
    chk("t4_fallo_rotar", rotar, 1);
    chk("t4_fallo_vidas", vidas, 2);

    // 6: asynchronous reset mid-RUN with altura=5 and a pulse in flight
    repeat (5) wait_paso(20, n);
    chk("t6_altura5", altura, 5);
    chk("t6_paso", paso_caida, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_altura", altura, 0);
    chk("t6_rst_nivel", nivel, 0);
    chk("t6_rst_vidas", vidas, 3);
    chk("t6_rst_activo", juego_activo, 0);
    chk("t6_rst_pulsos", {rotar, paso_caida}, 0);
    chk("t6_rst_estado", estado_dbg, IDLE);
    repeat (2) cyc();
    reset = 1'b1;
    start_game();
    wait_paso(60, n);
    chk("t6_gap", n, 20);
    chk("t6_altura1", altura, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
